// File: rtl/sync_schem.sv
// rtl/sync_schem.sv - 4-bit schematic-style T-flip-flop down counter with gate-level borrow chain
// Optional terminal-count output tc is built when SYNC_SCHEM_TC_EN is defined.
module sync_schem #(
  parameter logic [3:0] RESET_VALUE = 4'd15,
  parameter bit         WRAP        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic       out3
`ifdef SYNC_SCHEM_TC_EN
  ,
  output logic       tc
`endif
);

  logic [3:0] cnt;
  logic [3:0] t;
  logic [3:0] toggled;
  logic [3:0] nxt;
  logic       zero;
  logic       gate;

  assign cnt  = {out3, out2, out1, out0};
  assign zero = ~(out3 | out2 | out1 | out0);

  // Saturating build kills every toggle once the count reaches zero.
  assign gate = WRAP ? 1'b1 : ~zero;

  // Borrow chain: bit i toggles when all lower bits are zero.
  assign t[0] = en & gate;
  assign t[1] = en & ~out0 & gate;
  assign t[2] = en & ~out0 & ~out1 & gate;
  assign t[3] = en & ~out0 & ~out1 & ~out2 & gate;

  assign toggled = cnt ^ t;
  assign nxt     = load ? load_val : toggled;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out0 <= RESET_VALUE[0];
      out1 <= RESET_VALUE[1];
      out2 <= RESET_VALUE[2];
      out3 <= RESET_VALUE[3];
    end else begin
      out0 <= nxt[0];
      out1 <= nxt[1];
      out2 <= nxt[2];
      out3 <= nxt[3];
    end
  end

`ifdef SYNC_SCHEM_TC_EN
  assign tc = en & zero & rst & ~load;
`endif

endmodule

// File: tb/tb_sync_schem.sv
// tb/tb_sync_schem.sv - scoreboard bench for sync_schem, wrapping and saturating instances
module tb_sync_schem;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic w0, w1, w2, w3;
  logic s0, s1, s2, s3;
  logic tc_w, tc_s;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0] m_w;
  logic [3:0] m_s;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  sync_schem dut_wrap (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .out0(w0), .out1(w1), .out2(w2), .out3(w3)
`ifdef SYNC_SCHEM_TC_EN
    , .tc(tc_w)
`endif
  );

  sync_schem #(.RESET_VALUE(4'd15), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .out0(s0), .out1(s1), .out2(s2), .out3(s3)
`ifdef SYNC_SCHEM_TC_EN
    , .tc(tc_s)
`endif
  );

`ifndef SYNC_SCHEM_TC_EN
  assign tc_w = 1'b0;
  assign tc_s = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [3:0] m, input logic r, input logic l,
                                       input logic [3:0] lv, input logic e, input bit wrap);
    if (!r) return 4'd15;
    if (l) return lv;
    if (!e) return m;
    if (m == 4'd0) return wrap ? 4'd15 : 4'd0;
    return m - 4'd1;
  endfunction

  // Drive one vector, push expected counts, then compare after the edge.
  task automatic cycle(input logic r, input logic l, input logic [3:0] lv, input logic e);
    logic [7:0] exp;
    rst = r; load = l; load_val = lv; en = e;
`ifdef SYNC_SCHEM_TC_EN
    #1;
    check_val("tc_wrap", {3'b0, tc_w}, {3'b0, e & (m_w == 4'd0) & r & ~l});
    check_val("tc_sat",  {3'b0, tc_s}, {3'b0, e & (m_s == 4'd0) & r & ~l});
`endif
    m_w = model(m_w, r, l, lv, e, 1'b1);
    m_s = model(m_s, r, l, lv, e, 1'b0);
    sb_q.push_back({m_w, m_s});
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check_val("cnt_wrap", {w3, w2, w1, w0}, exp[7:4]);
    check_val("cnt_sat",  {s3, s2, s1, s0}, exp[3:0]);
  endtask

  initial begin
    m_w = 4'd0;
    m_s = 4'd0;
    @(posedge clk);
    #1;
    // Reset for two edges, then 20 enabled edges (wrap vs. saturate).
    repeat (2) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    repeat (20) cycle(1'b1, 1'b0, 4'd0, 1'b1);
    // Reset wins over load and enable while counting at 9.
    cycle(1'b1, 1'b1, 4'd10, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 1'b1, 4'd3, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    // Load beats enable, then reset glitch between edges is ignored.
    cycle(1'b1, 1'b1, 4'b0101, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    // Hold at 7, then one decrement.
    cycle(1'b1, 1'b1, 4'd7, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    // Terminal-count region: count 0 with/without enable, count 1 enabled.
    cycle(1'b1, 1'b1, 4'd0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    cycle(1'b1, 1'b1, 4'd1, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    // Random mix, reset kept rare.
    for (int i = 0; i < 40; i++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_schem.md
Name: sync_schem

Overview:
- Synchronous 4-bit down counter with individual bit outputs out3..out0 (out0 = LSB).
- Leaves reset at 15 (4'b1111) and decrements once per enabled clock edge toward 0.
- Implemented schematic-style: four T flip-flops whose toggle inputs come from an explicit gate-level borrow chain, plus synchronous load/reset muxing at each flip-flop D input.
- Used as a small timing/sequence source and as a gate-level reference counter in the design.

Parameters:
- RESET_VALUE, 4'd15: count loaded when reset is asserted (range 0..15).
- WRAP, 1: 1 = count wraps 0 -> 15 on the next enabled edge; 0 = count saturates (holds) at 0.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous active-low reset; sampled on the clk rising edge.
- en  input  1  count enable; when 1, decrement on the clk rising edge.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4  value captured when load=1.
- out0  output  1  count bit 0 (LSB), registered.
- out1  output  1  count bit 1, registered.
- out2  output  1  count bit 2, registered.
- out3  output  1  count bit 3 (MSB), registered.
- tc  output  1  terminal-count flag; present only with SYNC_SCHEM_TC_EN.

Behaviour:
- State: 4-bit register cnt = {out3,out2,out1,out0}. All outputs come directly from flip-flops, with no combinational path from inputs to out0..out3.
- Priority at each clk rising edge: rst==0 > load==1 > en==1 > hold.
- rst==0: cnt <= RESET_VALUE (default 4'b1111), regardless of en/load. Reset is synchronous only; rst changes between edges have no effect. Reset mid-count takes effect on the next edge.
- Power-up value is undefined until the first edge with rst==0.
- load==1 (rst==1): cnt <= load_val. Same-edge en is ignored.
- en==1, load==0, rst==1:
  - cnt != 0: cnt <= cnt - 1, modulo 16.
  - cnt == 0 and WRAP==1: cnt <= 4'b1111.
  - cnt == 0 and WRAP==0: cnt stays 0.
- en==0, load==0, rst==1: cnt holds.
- Latency: one clock from the qualifying edge to the new output value.
- Toggle logic, structural:
  - t0 = en
  - t1 = en & ~out0
  - t2 = en & ~out0 & ~out1
  - t3 = en & ~out0 & ~out1 & ~out2
  - With WRAP==0, gate all t_i with ~(cnt==0).
  - Each flip-flop D input = rst ? (load ? load_val[i] : out_i ^ t_i) : RESET_VALUE[i].
- One full sweep 15 -> 0 takes 15 enabled edges; the 16th enabled edge wraps to 15 (WRAP=1) or holds 0 (WRAP=0).

Optional Feature:
- Macro: SYNC_SCHEM_TC_EN.
- Defined: port tc is present. tc = en & (cnt == 0) & rst & ~load, combinational from the registered count and inputs. It indicates the next enabled edge would wrap or saturate.
- Not defined: tc port and its logic are absent. Counting behaviour is identical.

Test Plan:
- rst=0 for 2 edges, then rst=1, en=1 for 16 edges -> outputs 15 after reset, then 14, 13, ..., 0, then 15 (WRAP=1); {out3..out0} = 1111, 1110, ..., 0000, 1111.
- WRAP=0, count down from 15 with en=1 for 20 edges -> reaches 0 after 15 edges, stays 0 for the remaining 5; with macro, tc=1 while cnt=0 and en=1.
- Counting at 9, drive rst=0 for one edge with en=1 and load=1, load_val=3 -> count = 15 on that edge, then 14 on the next enabled edge.
- load=1, load_val=4'b0101 with en=1 -> count = 5; next enabled edge gives 4. Toggle rst low between clock edges only -> no change.
- Count at 7, en=0 for 5 edges -> holds 7. Then en=1 for one edge -> 6.
- With SYNC_SCHEM_TC_EN, count at 0, en=1 -> tc=1. en=0 -> tc=0. Count at 1, en=1 -> tc=0.
